// File: rtl/pb_varint_encoder_if.sv
// Handshake bundle between a value producer / byte consumer and the varint encoder.
// The master side offers values and accepts bytes; the encoder sits on the slave side.
interface pb_varint_encoder_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_zigzag;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_byte;
    logic              out_last;
    logic [3:0]        out_idx;

    modport master (
        output in_valid, in_data, in_zigzag, out_ready,
        input  in_ready, out_valid, out_byte, out_last, out_idx
    );

    modport slave (
        input  in_valid, in_data, in_zigzag, out_ready,
        output in_ready, out_valid, out_byte, out_last, out_idx
    );
endinterface

// File: rtl/pb_varint_encoder.sv
// Protobuf base-128 varint serialiser: one value in, LSB-first 7-bit groups out,
// one byte per cycle, bit7 set on every byte except the last.
module pb_varint_encoder #(
    parameter int DATA_W    = 64,
    parameter bit ZIGZAG_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    pb_varint_encoder_if.slave   bus
);
    localparam int         MAX_BYTES = (DATA_W + 6) / 7;
    localparam logic [3:0] LAST_IDX  = 4'(MAX_BYTES - 1);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] shreg_reg, shreg_next;
    logic [3:0]        idx_reg, idx_next;
    logic [DATA_W-1:0] zz_data;
    logic [DATA_W-1:0] load_data;
    logic              cont;
    logic              out_valid;
    logic              out_hs;
    logic              done;
    logic              in_ready;
    logic              accept;

    // ZigZag: (x << 1) ^ (x >>> DATA_W-1), built bit by bit.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_zz
            if (gi == 0) begin : g_lsb
                assign zz_data[gi] = bus.in_data[DATA_W-1];
            end else begin : g_bit
                assign zz_data[gi] = bus.in_data[gi-1] ^ bus.in_data[DATA_W-1];
            end
        end
    endgenerate

    assign load_data = (ZIGZAG_EN && bus.in_zigzag) ? zz_data : bus.in_data;

    // Continuation is simply "anything left above the current 7-bit group".
    assign cont      = |shreg_reg[DATA_W-1:7];
    assign out_valid = (state_reg == EMIT);
    assign out_hs    = out_valid & bus.out_ready;
    assign done      = out_hs & ~cont;
    assign in_ready  = ~rst & ((state_reg == IDLE) | done);
    assign accept    = bus.in_valid & in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_byte  = {cont, shreg_reg[6:0]};
    assign bus.out_last  = out_valid & ~cont;
    assign bus.out_idx   = idx_reg;

    always_comb begin
        state_next = state_reg;
        shreg_next = shreg_reg;
        idx_next   = idx_reg;

        case (state_reg)
            IDLE:    if (accept) state_next = EMIT;
            EMIT:    if (done && !accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // accept only happens in EMIT on the final byte, so it never collides with a shift
        if (accept) begin
            shreg_next = load_data;
            idx_next   = '0;
        end else if (out_hs && cont) begin
            shreg_next = shreg_reg >> 7;
            idx_next   = (idx_reg == LAST_IDX) ? idx_reg : idx_reg + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            shreg_reg <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            shreg_reg <= shreg_next;
            idx_reg   <= idx_next;
        end
    end
endmodule

// File: tb/tb_pb_varint_encoder.sv
// Scoreboard bench for pb_varint_encoder: stimulus pushes hand-computed bytes,
// monitors pop and compare on every output handshake.
module tb_pb_varint_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pb_varint_encoder_if #(.DATA_W(64)) ifc0 ();
    pb_varint_encoder_if #(.DATA_W(64)) ifc1 ();

    pb_varint_encoder #(.DATA_W(64), .ZIGZAG_EN(1'b1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (ifc0.slave)
    );

    pb_varint_encoder #(.DATA_W(64), .ZIGZAG_EN(1'b0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (ifc1.slave)
    );

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [12:0] q0[$];
    logic [12:0] q1[$];
    int          hs_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic exp_b(input bit which, input logic [7:0] b, input logic [3:0] idx, input logic last);
        if (which) q1.push_back({b, last, idx});
        else       q0.push_back({b, last, idx});
    endtask

    // Ten-byte image shared by all-ones, most-negative ZigZag and unsigned -1.
    task automatic exp_long(input bit which);
        for (int i = 0; i < 9; i++) exp_b(which, 8'hFF, 4'(i), 1'b0);
        exp_b(which, 8'h01, 4'd9, 1'b1);
    endtask

    task automatic mon_check(input string name, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got byte=%02h last=%0b idx=%0d expected byte=%02h last=%0b idx=%0d",
                     name, got[12:5], got[4], got[3:0], exp[12:5], exp[4], exp[3:0]);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && ifc0.out_valid && ifc0.out_ready) begin
                hs_cyc.push_back(cyc);
                if (q0.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte0 got byte=%02h last=%0b idx=%0d expected none",
                             ifc0.out_byte, ifc0.out_last, ifc0.out_idx);
                end else begin
                    mon_check("byte0", {ifc0.out_byte, ifc0.out_last, ifc0.out_idx}, q0.pop_front());
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && ifc1.out_valid && ifc1.out_ready) begin
                if (q1.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte1 got byte=%02h last=%0b idx=%0d expected none",
                             ifc1.out_byte, ifc1.out_last, ifc1.out_idx);
                end else begin
                    mon_check("byte1", {ifc1.out_byte, ifc1.out_last, ifc1.out_idx}, q1.pop_front());
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the value.
    task automatic send0(input logic [63:0] v, input logic zz);
        logic ok;
        ifc0.in_valid  = 1'b1;
        ifc0.in_data   = v;
        ifc0.in_zigzag = zz;
        for (int n = 0; n <= 100; n++) begin
            @(negedge clk);
            ok = ifc0.in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            if (n == 100) begin
                checks++;
                failures++;
                $display("FAIL send0_timeout got in_ready=0 expected 1 within 100 cycles");
            end
        end
        $display("send dut0 data=%016h zigzag=%0b cycle=%0d", v, zz, cyc);
    endtask

    task automatic send1(input logic [63:0] v, input logic zz);
        logic ok;
        ifc1.in_valid  = 1'b1;
        ifc1.in_data   = v;
        ifc1.in_zigzag = zz;
        for (int n = 0; n <= 100; n++) begin
            @(negedge clk);
            ok = ifc1.in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            if (n == 100) begin
                checks++;
                failures++;
                $display("FAIL send1_timeout got in_ready=0 expected 1 within 100 cycles");
            end
        end
        $display("send dut1 data=%016h zigzag=%0b cycle=%0d", v, zz, cyc);
    endtask

    task automatic drain();
        for (int n = 0; n <= 300; n++) begin
            if (q0.size() == 0 && q1.size() == 0 && !ifc0.out_valid && !ifc1.out_valid) return;
            if (n == 300) begin
                checks++;
                failures++;
                $display("FAIL drain_timeout got pending=%0d/%0d expected 0", q0.size(), q1.size());
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        ifc0.in_valid = 1'b0; ifc0.in_data = '0; ifc0.in_zigzag = 1'b0; ifc0.out_ready = 1'b1;
        ifc1.in_valid = 1'b0; ifc1.in_data = '0; ifc1.in_zigzag = 1'b0; ifc1.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  64'(ifc0.in_ready),  64'd0);
        chk("rst_out_valid", 64'(ifc0.out_valid), 64'd0);
        chk("rst_out_byte",  64'(ifc0.out_byte),  64'd0);
        chk("rst_out_last",  64'(ifc0.out_last),  64'd0);
        chk("rst_out_idx",   64'(ifc0.out_idx),   64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(ifc0.in_ready), 64'd1);
        @(posedge clk); #1;

        // Zero: single 0x00 byte, and in_ready already high during its handshake.
        exp_b(0, 8'h00, 4'd0, 1'b1);
        send0(64'd0, 1'b0);
        ifc0.in_valid = 1'b0;
        @(negedge clk);
        chk("zero_last",        64'(ifc0.out_last), 64'd1);
        chk("zero_ready_same",  64'(ifc0.in_ready), 64'd1);
        @(posedge clk); #1;
        drain();

        exp_b(0, 8'hAC, 4'd0, 1'b0);
        exp_b(0, 8'h02, 4'd1, 1'b1);
        send0(64'd300, 1'b0);
        exp_b(0, 8'h01, 4'd0, 1'b1);
        send0(64'd1, 1'b0);
        ifc0.in_valid = 1'b0;
        drain();

        exp_long(0);
        send0(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        ifc0.in_valid = 1'b0;
        drain();

        // ZigZag: -1 -> 1, -2 -> 3, most-negative -> all-ones.
        exp_b(0, 8'h01, 4'd0, 1'b1);
        send0(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        exp_b(0, 8'h03, 4'd0, 1'b1);
        send0(64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        exp_long(0);
        send0(64'h8000_0000_0000_0000, 1'b1);
        ifc0.in_valid = 1'b0;
        drain();

        // ZigZag disabled at build time: in_zigzag ignored.
        exp_long(1);
        send1(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        ifc1.in_valid = 1'b0;
        drain();

        // Backpressure: out_ready 1 at accept, 0,0 while 0x96 is shown, then 1.
        exp_b(0, 8'h96, 4'd0, 1'b0);
        exp_b(0, 8'h01, 4'd1, 1'b1);
        send0(64'd150, 1'b0);
        ifc0.in_valid  = 1'b0;
        ifc0.in_data   = 64'hDEAD_BEEF_0000_1234;
        ifc0.out_ready = 1'b0;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            chk("stall_valid", 64'(ifc0.out_valid), 64'd1);
            chk("stall_byte",  64'(ifc0.out_byte),  64'h96);
            chk("stall_last",  64'(ifc0.out_last),  64'd0);
            chk("stall_idx",   64'(ifc0.out_idx),   64'd0);
            @(posedge clk); #1;
        end
        ifc0.out_ready = 1'b1;
        drain();

        // Back-to-back at full rate: four handshakes on consecutive cycles.
        hs_cyc.delete();
        exp_b(0, 8'h96, 4'd0, 1'b0);
        exp_b(0, 8'h01, 4'd1, 1'b1);
        exp_b(0, 8'h01, 4'd0, 1'b1);
        exp_b(0, 8'h00, 4'd0, 1'b1);
        send0(64'd150, 1'b0);
        send0(64'd1, 1'b0);
        send0(64'd0, 1'b0);
        ifc0.in_valid = 1'b0;
        drain();
        chk("b2b_count", 64'(hs_cyc.size()), 64'd4);
        for (int i = 1; i < hs_cyc.size(); i++)
            chk("b2b_gap", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd1);

        // Reset after byte idx2 of a ten-byte value; the tail must vanish.
        exp_b(0, 8'hFF, 4'd0, 1'b0);
        exp_b(0, 8'hFF, 4'd1, 1'b0);
        exp_b(0, 8'hFF, 4'd2, 1'b0);
        ifc0.out_ready = 1'b0;
        send0(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        ifc0.in_valid  = 1'b0;
        ifc0.out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        ifc0.out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 64'(ifc0.in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ifc0.out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 64'(ifc0.out_valid), 64'd0);
        chk("midrst_pending",   64'(q0.size()),      64'd0);
        @(posedge clk); #1;
        exp_b(0, 8'h05, 4'd0, 1'b1);
        send0(64'd5, 1'b0);
        ifc0.in_valid = 1'b0;
        drain();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
